// File: rtl/key_entry_ctl_if.sv
// key_entry_ctl_if -- bundle between the keyboard decoder, the entry controller
// and the display/consumer side.
//   key_valid, last_change, key_down : decoder -> controller (scan-code events)
//   digit3..digit0                   : controller -> 7-seg nibbles (4'hF = blank)
//   entry_val, entry_done, entry_err : controller -> consumer (latched value, pulses)
//   state                            : controller FSM state (IDLE=0, ENTRY=1, DONE=2)
// master = driver of key events (decoder side), slave = the entry controller.
interface key_entry_ctl_if;
    logic         key_valid;
    logic [8:0]   last_change;
    logic [511:0] key_down;
    logic [3:0]   digit3;
    logic [3:0]   digit2;
    logic [3:0]   digit1;
    logic [3:0]   digit0;
    logic [15:0]  entry_val;
    logic         entry_done;
    logic         entry_err;
    logic [1:0]   state;

    modport master (
        output key_valid, last_change, key_down,
        input  digit3, digit2, digit1, digit0, entry_val, entry_done, entry_err, state
    );

    modport slave (
        input  key_valid, last_change, key_down,
        output digit3, digit2, digit1, digit0, entry_val, entry_done, entry_err, state
    );
endinterface

// File: rtl/key_entry_ctl.sv
// key_entry_ctl -- 4-digit BCD keypad entry controller fed by a PS/2 scan-code decoder.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : key_entry_ctl_if.slave (key events in; display digits, latched value,
//           done/error pulses and FSM state out)
// Digits shift in from the right; Backspace shifts back out, Enter latches the
// value, Esc or an idle timeout in ENTRY abandons the entry.
module key_entry_ctl #(
    parameter int unsigned TIMEOUT_CYC = 32'd500_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    key_entry_ctl_if.slave  bus
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StEntry = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [31:0] TimerLast = 32'(TIMEOUT_CYC - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] digits_q, digits_d;    // {digit3, digit2, digit1, digit0}
    logic [2:0]  count_q, count_d;
    logic [15:0] entry_val_q, entry_val_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] timer_q, timer_d;
    logic        kv_prev_q, kv_prev_d;
    logic        trk_valid_q, trk_valid_d;
    logic [8:0]  trk_code_q, trk_code_d;

    logic       press, accept;
    logic       is_digit, is_enter, is_bksp, is_esc;
    logic [3:0] dval;

    // Latched value reads blank nibbles as zero.
    function automatic logic [15:0] blank_to_zero(input logic [15:0] d);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (d[i*4 +: 4] == 4'hF) ? 4'h0 : d[i*4 +: 4];
        end
        return r;
    endfunction

    always_comb begin
        is_digit = 1'b0;
        is_enter = 1'b0;
        is_bksp  = 1'b0;
        is_esc   = 1'b0;
        dval     = 4'd0;
        case (bus.last_change)
            9'h045, 9'h070: begin is_digit = 1'b1; dval = 4'd0; end
            9'h016, 9'h069: begin is_digit = 1'b1; dval = 4'd1; end
            9'h01E, 9'h072: begin is_digit = 1'b1; dval = 4'd2; end
            9'h026, 9'h07A: begin is_digit = 1'b1; dval = 4'd3; end
            9'h025, 9'h06B: begin is_digit = 1'b1; dval = 4'd4; end
            9'h02E, 9'h073: begin is_digit = 1'b1; dval = 4'd5; end
            9'h036, 9'h074: begin is_digit = 1'b1; dval = 4'd6; end
            9'h03D, 9'h06C: begin is_digit = 1'b1; dval = 4'd7; end
            9'h03E, 9'h075: begin is_digit = 1'b1; dval = 4'd8; end
            9'h046, 9'h07D: begin is_digit = 1'b1; dval = 4'd9; end
            9'h05A, 9'h15A: is_enter = 1'b1;
            9'h066:         is_bksp  = 1'b1;
            9'h076:         is_esc   = 1'b1;
            default:        ;
        endcase
    end

    always_comb begin
        // Rising edge of key_valid on a code that is currently down.
        press  = bus.key_valid & ~kv_prev_q & bus.key_down[bus.last_change];
        // A held key's auto-repeat matches the tracked code and is dropped.
        accept = press & ~(trk_valid_q & (bus.last_change == trk_code_q));

        state_d     = state_q;
        digits_d    = digits_q;
        count_d     = count_q;
        entry_val_d = entry_val_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        timer_d     = timer_q;
        kv_prev_d   = bus.key_valid;
        trk_valid_d = trk_valid_q;
        trk_code_d  = trk_code_q;

        if (accept) begin
            trk_valid_d = 1'b1;
            trk_code_d  = bus.last_change;
        end else if (trk_valid_q && !bus.key_down[trk_code_q]) begin
            trk_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                timer_d = '0;
                if (accept && is_digit) begin
                    digits_d = {12'hFFF, dval};
                    count_d  = 3'd1;
                    state_d  = StEntry;
                end
            end
            StEntry: begin
                timer_d = timer_q + 32'd1;
                if (accept && is_digit) begin
                    timer_d = '0;
                    if (count_q < 3'd4) begin
                        digits_d = {digits_q[11:0], dval};
                        count_d  = count_q + 3'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (accept && is_bksp) begin
                    timer_d  = '0;
                    digits_d = {4'hF, digits_q[15:4]};
                    count_d  = count_q - 3'd1;
                    if (count_q == 3'd1) state_d = StIdle;
                end else if (accept && is_enter) begin
                    timer_d     = '0;
                    entry_val_d = blank_to_zero(digits_q);
                    done_d      = 1'b1;
                    state_d     = StDone;
                end else if ((accept && is_esc) || timer_q == TimerLast) begin
                    // Any decoded press above takes priority over an expiring timer.
                    timer_d  = '0;
                    digits_d = 16'hFFFF;
                    count_d  = 3'd0;
                    state_d  = StIdle;
                end
            end
            StDone: begin
                timer_d = '0;
                if (accept && is_digit) begin
                    digits_d = {12'hFFF, dval};
                    count_d  = 3'd1;
                    state_d  = StEntry;
                end else if (accept && is_esc) begin
                    digits_d = 16'hFFFF;
                    count_d  = 3'd0;
                    state_d  = StIdle;
                end
            end
            default: begin
                timer_d  = '0;
                digits_d = 16'hFFFF;
                count_d  = 3'd0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            digits_q    <= 16'hFFFF;
            count_q     <= 3'd0;
            entry_val_q <= 16'h0000;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            timer_q     <= '0;
            kv_prev_q   <= 1'b0;
            trk_valid_q <= 1'b0;
            trk_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            digits_q    <= digits_d;
            count_q     <= count_d;
            entry_val_q <= entry_val_d;
            done_q      <= done_d;
            err_q       <= err_d;
            timer_q     <= timer_d;
            kv_prev_q   <= kv_prev_d;
            trk_valid_q <= trk_valid_d;
            trk_code_q  <= trk_code_d;
        end
    end

    assign bus.digit3     = digits_q[15:12];
    assign bus.digit2     = digits_q[11:8];
    assign bus.digit1     = digits_q[7:4];
    assign bus.digit0     = digits_q[3:0];
    assign bus.entry_val  = entry_val_q;
    assign bus.entry_done = done_q;
    assign bus.entry_err  = err_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_key_entry_ctl.sv
// Bench for key_entry_ctl: directed scenarios against constants, then random key
// traffic against a queue-based reference model of the entry rules.
module tb_key_entry_ctl;
    localparam int unsigned TOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    key_entry_ctl_if bus ();

    key_entry_ctl #(.TIMEOUT_CYC(TOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_buf[$];      // entered digits, most recent at the back
    int          m_state;       // 0 idle, 1 entry, 2 done
    int          m_idle;        // cycles in ENTRY since last accepted event
    logic [15:0] m_val;
    logic        m_done, m_err, m_prev_kv, m_trk_on;
    logic [8:0]  m_trk;

    int main_codes[10] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025,
                           9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046};
    int kp_codes[10]   = '{9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B,
                           9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D};

    // returns 0..9 for digits, 10 enter, 11 backspace, 12 esc, -1 other
    function automatic int key_kind(input logic [8:0] c);
        for (int i = 0; i < 10; i++) begin
            if (int'(c) == main_codes[i] || int'(c) == kp_codes[i]) return i;
        end
        if (c == 9'h05A || c == 9'h15A) return 10;
        if (c == 9'h066) return 11;
        if (c == 9'h076) return 12;
        return -1;
    endfunction

    function automatic logic [15:0] model_digits();
        logic [15:0] r = 16'hFFFF;
        for (int i = 0; i < m_buf.size(); i++) r[i*4 +: 4] = 4'(m_buf[m_buf.size()-1-i]);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_buf.delete();
            m_state = 0; m_idle = 0; m_val = 16'h0; m_done = 0; m_err = 0;
            m_prev_kv = 0; m_trk_on = 0; m_trk = '0;
        end else begin
            logic [8:0] c;
            bit is_press, acc;
            int k;
            logic [15:0] d;
            c = bus.last_change;
            is_press = bus.key_valid && !m_prev_kv && bus.key_down[c];
            acc = is_press && !(m_trk_on && c == m_trk);
            m_prev_kv = bus.key_valid;
            if (acc) begin m_trk_on = 1; m_trk = c; end
            else if (m_trk_on && !bus.key_down[m_trk]) m_trk_on = 0;
            k = acc ? key_kind(c) : -1;
            m_done = 0; m_err = 0;
            if (m_state == 1) begin
                if (k >= 0) m_idle = 0;
                if (k >= 0 && k <= 9) begin
                    if (m_buf.size() < 4) m_buf.push_back(k); else m_err = 1;
                end else if (k == 11) begin
                    void'(m_buf.pop_back());
                    if (m_buf.size() == 0) m_state = 0;
                end else if (k == 10) begin
                    d = model_digits();
                    m_val = 0;
                    for (int i = 0; i < 4; i++)
                        if (d[i*4 +: 4] != 4'hF) m_val[i*4 +: 4] = d[i*4 +: 4];
                    m_done = 1; m_state = 2;
                end else if (k == 12) begin
                    m_buf.delete(); m_state = 0;
                end else if (m_idle == int'(TOUT) - 1) begin
                    m_buf.delete(); m_state = 0;
                end else begin
                    m_idle++;
                end
            end else if (k >= 0 && k <= 9) begin
                m_buf.delete(); m_buf.push_back(k); m_state = 1; m_idle = 0;
            end else if (m_state == 2 && k == 12) begin
                m_buf.delete(); m_state = 0;
            end
            if (m_state != 1) m_idle = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    // packed snapshot {state, d3, d2, d1, d0, done, err}
    function automatic logic [19:0] obs();
        return {bus.state, bus.digit3, bus.digit2, bus.digit1, bus.digit0,
                bus.entry_done, bus.entry_err};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // returns at the negedge after the sampling edge, outputs show the press
    task automatic press(input logic [8:0] c);
        bus.key_down[c] = 1'b1; bus.last_change = c; bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic release_key(input logic [8:0] c);
        @(negedge clk);
        bus.key_down[c] = 1'b0; bus.last_change = c; bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic tap(input logic [8:0] c);
        press(c);
        release_key(c);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tick(2);
        checks++;
        if (obs() !== {2'd0, 16'hFFFF, 2'b00} || bus.entry_val !== 16'h0) begin
            errors++;
            $display("FAIL reset_hold: got %h val %h, want %h val 0000", obs(), bus.entry_val,
                     {2'd0, 16'hFFFF, 2'b00});
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_fill_and_enter();
        tap(9'h016); tap(9'h01E); tap(9'h026);
        checks++;
        if (obs() !== {2'd1, 16'hF123, 2'b00}) begin
            errors++; $display("FAIL three_digits: got %h want %h", obs(), {2'd1, 16'hF123, 2'b00});
        end
        tap(9'h025);
        checks++;
        if (obs() !== {2'd1, 16'h1234, 2'b00}) begin
            errors++; $display("FAIL four_digits: got %h want %h", obs(), {2'd1, 16'h1234, 2'b00});
        end
        press(9'h02E);
        checks++;
        if (obs() !== {2'd1, 16'h1234, 2'b01}) begin
            errors++; $display("FAIL full_err: got %h want %h", obs(), {2'd1, 16'h1234, 2'b01});
        end
        tick(1);
        checks++;
        if (bus.entry_err !== 1'b0) begin
            errors++; $display("FAIL err_one_cycle: got %b want 0", bus.entry_err);
        end
        release_key(9'h02E);
        press(9'h05A);
        checks++;
        if (obs() !== {2'd2, 16'h1234, 2'b10} || bus.entry_val !== 16'h1234) begin
            errors++; $display("FAIL enter: got %h val %h want %h val 1234", obs(), bus.entry_val,
                               {2'd2, 16'h1234, 2'b10});
        end
        tick(1);
        checks++;
        if (bus.entry_done !== 1'b0) begin
            errors++; $display("FAIL done_one_cycle: got %b want 0", bus.entry_done);
        end
        release_key(9'h05A);
    endtask

    task automatic test_repeat();
        press(9'h03D);
        checks++;
        if (obs() !== {2'd1, 16'hFFF7, 2'b00}) begin
            errors++; $display("FAIL done_new_entry: got %h want %h", obs(), {2'd1, 16'hFFF7, 2'b00});
        end
        for (int i = 0; i < 3; i++) begin
            tick(1);
            bus.last_change = 9'h03D; bus.key_valid = 1'b1;
            @(negedge clk);
            bus.key_valid = 1'b0;
        end
        checks++;
        if (obs() !== {2'd1, 16'hFFF7, 2'b00}) begin
            errors++; $display("FAIL repeat_suppress: got %h want %h", obs(), {2'd1, 16'hFFF7, 2'b00});
        end
        release_key(9'h03D);
        tap(9'h03D);
        checks++;
        if (obs() !== {2'd1, 16'hFF77, 2'b00}) begin
            errors++; $display("FAIL repress: got %h want %h", obs(), {2'd1, 16'hFF77, 2'b00});
        end
    endtask

    task automatic test_bksp_keypad_enter();
        tap(9'h076);
        tap(9'h07D);
        checks++;
        if (obs() !== {2'd1, 16'hFFF9, 2'b00}) begin
            errors++; $display("FAIL keypad_9: got %h want %h", obs(), {2'd1, 16'hFFF9, 2'b00});
        end
        tap(9'h066);
        checks++;
        if (obs() !== {2'd0, 16'hFFFF, 2'b00}) begin
            errors++; $display("FAIL bksp_to_idle: got %h want %h", obs(), {2'd0, 16'hFFFF, 2'b00});
        end
        press(9'h05A);
        checks++;
        if (obs() !== {2'd0, 16'hFFFF, 2'b00}) begin
            errors++; $display("FAIL enter_in_idle: got %h want %h", obs(), {2'd0, 16'hFFFF, 2'b00});
        end
        release_key(9'h05A);
        tap(9'h03E);
        press(9'h15A);
        checks++;
        if (obs() !== {2'd2, 16'hFFF8, 2'b10} || bus.entry_val !== 16'h0008) begin
            errors++; $display("FAIL kp_enter: got %h val %h want %h val 0008", obs(), bus.entry_val,
                               {2'd2, 16'hFFF8, 2'b10});
        end
        release_key(9'h15A);
    endtask

    task automatic test_timeout();
        tap(9'h076);
        press(9'h02E);
        tick(TOUT - 1);
        checks++;
        if (obs() !== {2'd1, 16'hFFF5, 2'b00}) begin
            errors++; $display("FAIL before_timeout: got %h want %h", obs(), {2'd1, 16'hFFF5, 2'b00});
        end
        tick(1);
        checks++;
        if (obs() !== {2'd0, 16'hFFFF, 2'b00}) begin
            errors++; $display("FAIL timeout: got %h want %h", obs(), {2'd0, 16'hFFFF, 2'b00});
        end
        release_key(9'h02E);
        press(9'h036);
        tick(TOUT - 1);
        press(9'h026);     // sampled on the expiry edge
        checks++;
        if (obs() !== {2'd1, 16'hFF63, 2'b00}) begin
            errors++; $display("FAIL press_wins: got %h want %h", obs(), {2'd1, 16'hFF63, 2'b00});
        end
        tick(TOUT - 1);
        checks++;
        if (obs() !== {2'd1, 16'hFF63, 2'b00}) begin
            errors++; $display("FAIL timer_cleared: got %h want %h", obs(), {2'd1, 16'hFF63, 2'b00});
        end
        tick(1);
        checks++;
        if (obs() !== {2'd0, 16'hFFFF, 2'b00}) begin
            errors++; $display("FAIL second_timeout: got %h want %h", obs(), {2'd0, 16'hFFFF, 2'b00});
        end
        release_key(9'h036);
        release_key(9'h026);
    endtask

    task automatic test_async_reset();
        tap(9'h016); tap(9'h01E);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== {2'd0, 16'hFFFF, 2'b00} || bus.entry_val !== 16'h0) begin
            errors++; $display("FAIL async_reset: got %h val %h want %h val 0000", obs(),
                               bus.entry_val, {2'd0, 16'hFFFF, 2'b00});
        end
        @(negedge clk);
        bus.key_down = '0;
        rst_n = 1'b1;
        press(9'h025);
        checks++;
        if (obs() !== {2'd1, 16'hFFF4, 2'b00}) begin
            errors++; $display("FAIL first_after_reset: got %h want %h", obs(),
                               {2'd1, 16'hFFF4, 2'b00});
        end
        release_key(9'h025);
    endtask

    task automatic test_random();
        logic [8:0] c;
        int sel, fails;
        fails = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                bus.key_valid = 1'b0;
                tick(TOUT + 4);
            end
            if ($urandom_range(0, 9) < 4) begin
                bus.key_valid = 1'b0;
            end else begin
                sel = $urandom_range(0, 15);
                if (sel < 10) c = 9'(($urandom_range(0, 1) == 0) ? main_codes[sel] : kp_codes[sel]);
                else if (sel == 10) c = 9'h05A;
                else if (sel == 11) c = 9'h15A;
                else if (sel == 12) c = 9'h066;
                else if (sel == 13) c = 9'h076;
                else if (sel == 14) c = 9'h01C;
                else c = 9'h11C;
                bus.last_change = c;
                bus.key_down[c] = ($urandom_range(0, 3) != 0);
                bus.key_valid = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (obs() !== {2'(m_state), model_digits(), m_done, m_err} || bus.entry_val !== m_val) begin
                errors++;
                if (fails < 10)
                    $display("FAIL random[%0d]: got %h val %h want %h val %h", i, obs(),
                             bus.entry_val, {2'(m_state), model_digits(), m_done, m_err}, m_val);
                fails++;
            end
        end
        bus.key_valid = 1'b0;
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.last_change = '0;
        bus.key_down = '0;
        test_reset();
        test_fill_and_enter();
        test_repeat();
        test_bksp_keypad_enter();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end
endmodule

// File: doc/key_entry_ctl.md
KEY_ENTRY_CTL -- requirements
Module: key_entry_ctl

Interface
REQ-001 Parameter: TIMEOUT_CYC, 500_000_000, idle cycles in ENTRY before the entry is abandoned (5 s at 100 MHz); legal range 2..2^32-1.
REQ-002 Port: clk  input  1  system clock (100 MHz); all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: key_valid  input  1  keyboard decoder event strobe.
REQ-005 Port: last_change  input  9  keyboard decoder scan code; bit 8 = E0-extended.
REQ-006 Port: key_down  input  512  keyboard decoder per-code pressed map.
REQ-007 Port: digit3..digit0  output  4 each  display nibbles for the 7-seg controller; 4'hF = blank, digit0 rightmost.
REQ-008 Port: entry_val  output  16  BCD value {d3,d2,d1,d0} latched on Enter; blanks read as 0.
REQ-009 Port: entry_done  output  1  one-cycle pulse when entry_val is updated.
REQ-010 Port: entry_err  output  1  one-cycle pulse on a rejected digit (buffer full).
REQ-011 Port: state  output  2  current FSM state (IDLE=0, ENTRY=1, DONE=2).

Function
REQ-012 A press event SHALL be the cycle where key_valid=1, key_valid was 0 the previous cycle, and key_down[last_change]=1; release events SHALL be ignored.
REQ-013 Auto-repeat suppression: after a press of code C is accepted, further press events of C SHALL be ignored until key_down[C]=0 is sampled; presses of any other code SHALL be accepted immediately and re-arm tracking to that code.
REQ-014 Decode: digits 0-9 = 9'h045,016,01E,026,025,02E,036,03D,03E,046 and keypad 9'h070,069,072,07A,06B,073,074,06C,075,07D; Enter = 9'h05A or 9'h15A; Backspace = 9'h066; Esc = 9'h076; all other codes SHALL be ignored (no state or timer change).
REQ-015 FSM IDLE: all digits blank; digit -> ENTRY with that digit in digit0; Enter/Backspace/Esc ignored.
REQ-016 FSM ENTRY, digit with count<4: shift left (digit3<=digit2 ... digit0<=new), count+1.
REQ-017 FSM ENTRY, digit with count=4: buffer unchanged, entry_err pulse.
REQ-018 FSM ENTRY, Backspace: shift right, digit3<=F, count-1; count reaching 0 -> IDLE.
REQ-019 FSM ENTRY, Enter: entry_val<=digits with F mapped to 0, entry_done pulse, -> DONE; digits stay displayed.
REQ-020 FSM ENTRY, Esc: all digits blank, count=0 -> IDLE; entry_val unchanged.
REQ-021 FSM DONE: digit clears buffer and starts a new entry with that digit (-> ENTRY, count=1); Esc -> IDLE; Enter/Backspace ignored.
REQ-022 Timeout counter SHALL run only in ENTRY, clear on every accepted event and on ENTRY entry; on reaching TIMEOUT_CYC-1 the block SHALL behave as Esc.
REQ-023 A press event in the same cycle as timeout expiry SHALL win; the timeout is discarded and the counter cleared.
REQ-024 Latency: outputs SHALL reflect an event one clock after the qualifying key_valid edge; entry_done/entry_err SHALL assert in that same cycle for exactly one cycle.
REQ-025 Only one event SHALL be processed per cycle; key_valid held high SHALL not generate repeat events.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, digit3..0=4'hF, count=0, entry_val=16'h0000, entry_done=0, entry_err=0, timer=0, previous key_valid=0, repeat tracking cleared, including mid-entry.
REQ-027 The first qualifying edge after rst_n rises SHALL be processed normally.

Verification
REQ-028 Press/release 1,2,3 (9'h016,01E,026) -> digits F,1,2,3; state=ENTRY; count=3.
REQ-029 Then press 4, 5 -> digits 1,2,3,4; entry_err pulses once on 5; Enter -> entry_val=16'h1234, entry_done 1 cycle, state=DONE.
REQ-030 Press 7, repeat key_valid edges with key_down[9'h03D] held, release, press 7 -> digits F,F,7,7 only.
REQ-031 Enter 9,Backspace -> IDLE all blank; Enter in IDLE -> no entry_done; keypad Enter 9'h15A after 8 -> entry_val=16'h0008.
REQ-032 TIMEOUT_CYC=16: press 5, idle 16 cycles -> IDLE, blank; press on expiry cycle -> digit accepted, state ENTRY.
REQ-033 Assert rst_n=0 mid-entry between clock edges -> outputs at reset values before next clk edge.
